// File: rtl/fsk_frame_modulator.sv
`default_nettype none
// ============================================================================
// Module   : fsk_frame_modulator
// Brief    : UART-style framer (start, data LSB-first, stop) driving a
//            continuous-phase binary FSK square wave from half-period counters.
// Revision : 1.0
// ============================================================================
module fsk_frame_modulator #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 32,
    parameter int MARK_HALF  = 4,
    parameter int SPACE_HALF = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              fsk_out,
    output logic              tx_bit,
    output logic              busy,
    output logic              bit_strobe
);

    localparam int c_MAX_HALF = (MARK_HALF > SPACE_HALF) ? MARK_HALF : SPACE_HALF;
    localparam int c_BW       = $clog2(BAUD_DIV + 1);
    localparam int c_TW       = $clog2(c_MAX_HALF + 1);
    localparam int c_IW       = $clog2(DATA_W + 1);

    localparam logic [c_BW-1:0] c_BAUD_LAST  = c_BW'(BAUD_DIV - 1);
    localparam logic [c_TW-1:0] c_MARK_LAST  = c_TW'(MARK_HALF - 1);
    localparam logic [c_TW-1:0] c_SPACE_LAST = c_TW'(SPACE_HALF - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_BW-1:0]   r_baud_cnt;
    logic [c_IW-1:0]   r_bit_idx;
    logic [c_TW-1:0]   r_tone_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_fsk;
    logic              w_sym_end;
    logic              w_accept;
    logic              w_last_bit;
    logic [c_TW-1:0]   w_half_last;

    assign w_sym_end  = (r_state != S_IDLE) && (r_baud_cnt == c_BAUD_LAST);
    assign w_last_bit = (r_bit_idx == c_IDX_LAST);

    // Ready in IDLE and on the final STOP cycle; held low while reset is high.
    assign data_ready = !reset &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_STOP) && (r_baud_cnt == c_BAUD_LAST)));
    assign w_accept   = data_valid && data_ready;

    assign busy        = (r_state != S_IDLE);
    assign bit_strobe  = w_sym_end;
    assign fsk_out     = r_fsk;
    assign w_half_last = tx_bit ? c_MARK_LAST : c_SPACE_LAST;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        tx_bit       = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                tx_bit = 1'b0;
                if (w_sym_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx_bit = r_shreg[0];
                if (w_sym_end && w_last_bit) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sym_end) begin
                    w_state_next = w_accept ? S_START : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_shreg    <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tone_cnt <= '0;
            r_fsk      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shreg <= data_in;
            end else if ((r_state == S_DATA) && w_sym_end) begin
                r_shreg <= r_shreg >> 1;
            end

            if ((r_state == S_IDLE) || w_sym_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if ((r_state == S_DATA) && w_sym_end) begin
                r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
            end

            // Carrier is off in IDLE; otherwise toggle on the current half,
            // and a symbol boundary restarts the count without touching phase.
            if ((r_state == S_IDLE) || (w_state_next == S_IDLE)) begin
                r_fsk      <= 1'b0;
                r_tone_cnt <= '0;
            end else begin
                if (r_tone_cnt == w_half_last) begin
                    r_fsk      <= ~r_fsk;
                    r_tone_cnt <= '0;
                end else begin
                    r_tone_cnt <= r_tone_cnt + 1'b1;
                end
                if (w_sym_end) begin
                    r_tone_cnt <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsk_frame_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsk_frame_modulator
// Brief    : Directed + random-byte bench with a symbol/tone reference model.
// Revision : 1.0
// ============================================================================
module tb_fsk_frame_modulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in, data_in_c;
    logic       data_valid, data_valid_c;
    logic       dr_m, fsk_m, tx_m, busy_m, stb_m;
    logic       dr_c, fsk_c, tx_c, busy_c, stb_c;

    int   n_cmp = 0;
    int   n_mis = 0;
    logic m_level = 1'b0;

    always #5 clk = ~clk;

    fsk_frame_modulator #(
        .DATA_W(8), .BAUD_DIV(32), .MARK_HALF(4), .SPACE_HALF(8)
    ) u_dut (
        .clk_in(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(dr_m), .fsk_out(fsk_m), .tx_bit(tx_m), .busy(busy_m),
        .bit_strobe(stb_m)
    );

    fsk_frame_modulator #(
        .DATA_W(8), .BAUD_DIV(2), .MARK_HALF(1), .SPACE_HALF(1)
    ) u_dut_c (
        .clk_in(clk), .reset(reset), .data_in(data_in_c), .data_valid(data_valid_c),
        .data_ready(dr_c), .fsk_out(fsk_c), .tx_bit(tx_c), .busy(busy_c),
        .bit_strobe(stb_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic drive(input bit c, input logic v, input logic [7:0] d);
        if (c) begin
            data_valid_c = v;
            data_in_c    = d;
        end else begin
            data_valid = v;
            data_in    = d;
        end
    endtask

    task automatic check_idle(input bit c, input int k);
        chk(c ? "idle_ready_c" : "idle_ready", k, c ? dr_c : dr_m, 1'b1);
        chk(c ? "idle_fsk_c" : "idle_fsk", k, c ? fsk_c : fsk_m, 1'b0);
        chk(c ? "idle_busy_c" : "idle_busy", k, c ? busy_c : busy_m, 1'b0);
        chk(c ? "idle_tx_c" : "idle_tx", k, c ? tx_c : tx_m, 1'b1);
        chk(c ? "idle_stb_c" : "idle_stb", k, c ? stb_c : stb_m, 1'b0);
    endtask

    task automatic check_reset(input int k);
        chk("rst_ready", k, dr_m, 1'b0);
        chk("rst_fsk", k, fsk_m, 1'b0);
        chk("rst_tx", k, tx_m, 1'b1);
        chk("rst_busy", k, busy_m, 1'b0);
        chk("rst_stb", k, stb_m, 1'b0);
        chk("rst_ready_c", k, dr_c, 1'b0);
        chk("rst_fsk_c", k, fsk_c, 1'b0);
        chk("rst_busy_c", k, busy_c, 1'b0);
    endtask

    // Handshake a byte from IDLE; returns positioned at frame cycle 0 (START).
    task automatic start_frame(input bit c, input logic [7:0] b);
        int w;
        w = 0;
        drive(c, 1'b1, b);
        while (!(c ? dr_c : dr_m) && (w < 20)) begin
            tick();
            w++;
        end
        chk("handshake_wait", w, (w < 20) ? 1'b1 : 1'b0, 1'b1);
        tick();
        m_level = 1'b0;
    endtask

    // Walks one frame cycle by cycle against the symbol/tone model.
    // have_next holds the next byte valid so it is taken on the last STOP cycle.
    task automatic do_frame(input bit c, input logic [7:0] b, input bit have_next,
                            input logic [7:0] nb, input int abort_at);
        int   baud, mark, space, n, sym, p, half;
        logic bitv;
        baud  = c ? 2 : 32;
        mark  = c ? 1 : 4;
        space = c ? 1 : 8;
        n     = 10 * baud;
        for (int k = 0; k < n; k++) begin
            sym  = k / baud;
            p    = k % baud;
            bitv = (sym == 0) ? 1'b0 : (sym == 9) ? 1'b1 : b[sym-1];
            half = bitv ? mark : space;
            if (have_next) drive(c, 1'b1, nb);
            else           drive(c, 1'b0, 8'($urandom));
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check_reset(k);
                m_level = 1'b0;
                return;
            end
            chk(c ? "tx_bit_c" : "tx_bit", k, c ? tx_c : tx_m, bitv);
            chk(c ? "fsk_c" : "fsk", k, c ? fsk_c : fsk_m, m_level);
            chk(c ? "busy_c" : "busy", k, c ? busy_c : busy_m, 1'b1);
            chk(c ? "strobe_c" : "strobe", k, c ? stb_c : stb_m, (p == baud - 1) ? 1'b1 : 1'b0);
            chk(c ? "ready_c" : "ready", k, c ? dr_c : dr_m, (k == n - 1) ? 1'b1 : 1'b0);
            if (((p + 1) % half) == 0) m_level = ~m_level;
            tick();
        end
        if (!have_next) begin
            m_level = 1'b0;
            drive(c, 1'b0, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] b, b2;
        reset        = 1'b1;
        data_valid   = 1'b0;
        data_valid_c = 1'b0;
        data_in      = 8'h00;
        data_in_c    = 8'h00;

        repeat (3) begin
            tick();
            check_reset(0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle(1'b0, i);
            check_idle(1'b1, i);
        end

        start_frame(1'b0, 8'hA5);
        do_frame(1'b0, 8'hA5, 1'b0, 8'h00, -1);
        check_idle(1'b0, 0);

        for (int f = 0; f < 4; f++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            start_frame(1'b0, b);
            do_frame(1'b0, b, 1'b0, 8'h00, -1);
            check_idle(1'b0, f);
        end

        start_frame(1'b0, 8'h00);
        do_frame(1'b0, 8'h00, 1'b1, 8'hFF, -1);
        do_frame(1'b0, 8'hFF, 1'b0, 8'h00, -1);
        check_idle(1'b0, 1);

        b  = 8'($urandom);
        b2 = 8'($urandom);
        start_frame(1'b0, b);
        do_frame(1'b0, b, 1'b1, b2, -1);
        do_frame(1'b0, b2, 1'b0, 8'h00, -1);
        check_idle(1'b0, 2);

        b = 8'($urandom);
        start_frame(1'b0, b);
        do_frame(1'b0, b, 1'b0, 8'h00, 100);
        repeat (2) begin
            tick();
            check_reset(1);
        end
        reset = 1'b0;
        tick();
        check_idle(1'b0, 3);
        start_frame(1'b0, 8'h3C);
        do_frame(1'b0, 8'h3C, 1'b0, 8'h00, -1);
        check_idle(1'b0, 4);

        start_frame(1'b1, 8'h01);
        do_frame(1'b1, 8'h01, 1'b0, 8'h00, -1);
        check_idle(1'b1, 0);
        b  = 8'($urandom);
        b2 = 8'($urandom);
        start_frame(1'b1, b);
        do_frame(1'b1, b, 1'b1, b2, -1);
        do_frame(1'b1, b2, 1'b0, 8'h00, -1);
        check_idle(1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
